// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_if
//  Purpose  : Request / grant / broadcast bundle between the execution units
//             and the Common Data Bus arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
);
  logic                      flush;
  logic                      rr_enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_grant;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic                      starve_event;

  // Execution-unit / pipeline-control side
  modport master (
    output flush, rr_enable, req_valid, req_tag, req_data,
    input  req_grant, cdb_valid, cdb_tag, cdb_data, starve_event
  );

  // Arbiter side
  modport slave (
    input  flush, rr_enable, req_valid, req_tag, req_data,
    output req_grant, cdb_valid, cdb_tag, cdb_data, starve_event
  );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Picks one completed execution-unit result per cycle and drives
//             a registered Common Data Bus broadcast. Round-robin or fixed
//             priority with a starvation override.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TAG_W        = 6,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 7
) (
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   C_NUM   = (PTR_W + 1)'(NUM_REQ);

  logic [PTR_W-1:0]  rr_ptr_q,       rr_ptr_d;
  logic [CNT_W-1:0]  starve_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]  starve_cnt_d [NUM_REQ];
  logic              cdb_valid_q,    cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q,      cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q,     cdb_data_d;
  logic              starve_event_q, starve_event_d;

  logic              win_found;
  logic              win_forced;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W:0]    scan_idx;
  logic [NUM_REQ-1:0] grant;

  // Winner selection: nothing while flushing or in reset; otherwise either a
  // wrapping search from rr_ptr, or starving-first then lowest-index.
  always_comb begin
    win_found  = 1'b0;
    win_forced = 1'b0;
    win_idx    = '0;
    scan_idx   = '0;
    if (!reset && !bus.flush) begin
      if (bus.rr_enable) begin
        for (int off = 0; off < NUM_REQ; off++) begin
          scan_idx = {1'b0, rr_ptr_q} + (PTR_W + 1)'(off);
          if (scan_idx >= C_NUM) begin
            scan_idx = scan_idx - C_NUM;
          end
          if (!win_found && bus.req_valid[scan_idx[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[PTR_W-1:0];
          end
        end
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!win_found && bus.req_valid[i] && (starve_cnt_q[i] == C_LIMIT)) begin
            win_found  = 1'b1;
            win_forced = 1'b1;
            win_idx    = PTR_W'(i);
          end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!win_found && bus.req_valid[i]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(i);
          end
        end
      end
    end
  end

  // One-hot grant decode of the winner index.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = win_found && (win_idx == PTR_W'(i));
    end
  end

  assign bus.req_grant = grant;

  // Next-state: broadcast capture, pointer advance and starvation counters.
  // Counters track in both modes so a mode switch carries the history over.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    cdb_valid_d    = win_found;
    cdb_tag_d      = cdb_tag_q;
    cdb_data_d     = cdb_data_q;
    starve_event_d = win_found && win_forced;
    if (win_found) begin
      rr_ptr_d   = (win_idx == C_LAST) ? '0 : win_idx + 1'b1;
      cdb_tag_d  = bus.req_tag[win_idx * TAG_W +: TAG_W];
      cdb_data_d = bus.req_data[win_idx * DATA_W +: DATA_W];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      starve_cnt_d[i] = starve_cnt_q[i];
      if (bus.flush || !bus.req_valid[i] || grant[i]) begin
        starve_cnt_d[i] = '0;
      end else if (starve_cnt_q[i] < C_LIMIT) begin
        starve_cnt_d[i] = starve_cnt_q[i] + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_data_q     <= '0;
      starve_event_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        starve_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_data_q     <= cdb_data_d;
      starve_event_q <= starve_event_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        starve_cnt_q[i] <= starve_cnt_d[i];
      end
    end
  end

  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_tag      = cdb_tag_q;
  assign bus.cdb_data     = cdb_data_q;
  assign bus.starve_event = starve_event_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter; expected broadcasts are
//             queued when a grant is expected and popped one cycle later.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              forced;
  } exp_t;

  logic clk;
  logic reset;
  int   errs;
  int   checks;
  exp_t exp_q [$];

  cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(
    .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W), .STARVE_LIMIT(7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, and reports any mismatch.
  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
    bus.req_valid[i]               = v;
    bus.req_tag[i*TAG_W +: TAG_W]  = t;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Post-edge broadcast check against the scoreboard head.
  task automatic check_cdb(input string nm);
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({nm, "_valid"}, 64'(bus.cdb_valid), 64'd1);
      chk({nm, "_tag"},   64'(bus.cdb_tag),   64'(e.tag));
      chk({nm, "_data"},  64'(bus.cdb_data),  64'(e.data));
      chk({nm, "_starve"}, 64'(bus.starve_event), 64'(e.forced));
    end else begin
      chk({nm, "_valid"}, 64'(bus.cdb_valid), 64'd0);
      chk({nm, "_starve"}, 64'(bus.starve_event), 64'd0);
    end
  endtask

  // One cycle: check the grant mid-cycle, queue the expected broadcast,
  // then check the bus just after the edge.
  task automatic step(input logic [NUM_REQ-1:0] exp_grant, input logic exp_forced,
                      input string nm);
    exp_t e;
    @(negedge clk);
    chk({nm, "_grant"}, 64'(bus.req_grant), 64'(exp_grant));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_grant[i]) begin
        e.tag    = bus.req_tag[i*TAG_W +: TAG_W];
        e.data   = bus.req_data[i*DATA_W +: DATA_W];
        e.forced = exp_forced;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_cdb(nm);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errs   = 0;
    checks = 0;
    reset  = 1'b1;
    bus.flush     = 1'b0;
    bus.rr_enable = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, TAG_W'(i + 1), DATA_W'(32'hA000 + i));

    // Reset with every unit requesting.
    step(4'b0000, 1'b0, "rst0");
    step(4'b0000, 1'b0, "rst1");
    chk("rst_tag",  64'(bus.cdb_tag),  64'd0);
    chk("rst_data", 64'(bus.cdb_data), 64'd0);
    reset = 1'b0;
    clear_all();
    step(4'b0000, 1'b0, "idle");

    // Single requester, then idle afterwards.
    set_req(2, 1'b1, 6'h15, 32'hDEADBEEF);
    step(4'b0100, 1'b0, "single");
    clear_all();
    step(4'b0000, 1'b0, "single_after");

    // Bring the pointer back to 0 via unit 3, then full contention.
    set_req(3, 1'b1, 6'h33, 32'h3333_0000);
    step(4'b1000, 1'b0, "wrap");
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, TAG_W'(6'h10 + i), DATA_W'(32'hC0DE_0000 + i));
    step(4'b0001, 1'b0, "rr0");
    step(4'b0010, 1'b0, "rr1");
    step(4'b0100, 1'b0, "rr2");
    step(4'b1000, 1'b0, "rr3");
    step(4'b0001, 1'b0, "rr4");
    clear_all();
    step(4'b0000, 1'b0, "rr_idle");

    // Fixed priority: unit 0 keeps winning until unit 3 starves out.
    bus.rr_enable = 1'b0;
    set_req(3, 1'b1, 6'h3F, 32'hFFFF_0003);
    for (int c = 0; c < 7; c++) begin
      set_req(0, 1'b1, TAG_W'(6'h20 + c), DATA_W'(32'h5000 + c));
      step(4'b0001, 1'b0, "fixed_win0");
    end
    set_req(0, 1'b1, 6'h28, 32'h5008);
    step(4'b1000, 1'b1, "starve_grant");
    set_req(3, 1'b0, '0, '0);
    set_req(0, 1'b1, 6'h29, 32'h5009);
    step(4'b0001, 1'b0, "after_starve");
    clear_all();
    step(4'b0000, 1'b0, "fixed_idle");

    // Flush suppresses the grant, then unit 1 wins.
    bus.rr_enable = 1'b1;
    set_req(1, 1'b1, 6'h11, 32'h1111_1111);
    set_req(2, 1'b1, 6'h22, 32'h2222_2222);
    bus.flush = 1'b1;
    step(4'b0000, 1'b0, "flush");
    bus.flush = 1'b0;
    step(4'b0010, 1'b0, "post_flush");
    set_req(1, 1'b0, '0, '0);
    step(4'b0100, 1'b0, "pre_flush2");
    clear_all();
    bus.flush = 1'b1;
    step(4'b0000, 1'b0, "flush2");
    bus.flush = 1'b0;

    // Reset right after a grant: pending broadcast dropped, pointer to 0.
    set_req(1, 1'b1, 6'h07, 32'h0707_0707);
    step(4'b0010, 1'b0, "pre_reset");
    reset = 1'b1;
    step(4'b0000, 1'b0, "mid_reset");
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, TAG_W'(6'h30 + i), DATA_W'(32'h9000 + i));
    step(4'b0001, 1'b0, "ptr_after_reset");

    // Mode switch takes effect in the same cycle (pointer now 1).
    clear_all();
    set_req(0, 1'b1, 6'h01, 32'hAAAA_0000);
    set_req(2, 1'b1, 6'h02, 32'hAAAA_0002);
    bus.rr_enable = 1'b0;
    step(4'b0001, 1'b0, "mode_fixed");
    bus.rr_enable = 1'b1;
    step(4'b0100, 1'b0, "mode_rr");
    clear_all();
    step(4'b0000, 1'b0, "final_idle");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
